// File: rtl/uart_block_packer.sv
// Packs UART receiver bytes big-endian into a SHA-256 message block and hands
// the completed block to the hash core over a valid/ready handshake.
module uart_block_packer #(
  parameter  int UART_DATA_WIDTH = 8,
  parameter  int BYTES_PER_BLOCK = 64,
  localparam int BLOCK_WIDTH     = UART_DATA_WIDTH * BYTES_PER_BLOCK,
  localparam int CW              = $clog2(BYTES_PER_BLOCK + 1)
) (
  input  logic                       i_Clock,
  input  logic                       i_Rst_n,
  input  logic                       i_Rx_DV,
  input  logic [UART_DATA_WIDTH-1:0] i_Rx_Byte,
  input  logic                       i_Flush,
  output logic [BLOCK_WIDTH-1:0]     o_Block,
  output logic                       o_Block_Valid,
  input  logic                       i_Block_Ready,
  output logic [CW-1:0]              o_Byte_Count,
  output logic                       o_Overrun
);

  localparam int SW = $clog2(BYTES_PER_BLOCK);

  typedef enum logic [1:0] {
    S_FILL = 2'b01,
    S_HOLD = 2'b10
  } state_t;

  state_t                   state_q, state_d;
  logic [BLOCK_WIDTH-1:0]   buf_q, buf_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     ovr_q, ovr_d;
  int unsigned              slot;

  // Constant-index unrolled write keeps the byte lane select free of width games.
  function automatic logic [BLOCK_WIDTH-1:0] write_slot(
    input logic [BLOCK_WIDTH-1:0]     blk,
    input int unsigned                idx,
    input logic [UART_DATA_WIDTH-1:0] b
  );
    logic [BLOCK_WIDTH-1:0] r;
    r = blk;
    for (int unsigned i = 0; i < BYTES_PER_BLOCK; i++) begin
      if (idx == i) r[BLOCK_WIDTH-1-UART_DATA_WIDTH*i -: UART_DATA_WIDTH] = b;
    end
    return r;
  endfunction

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state_q <= S_FILL;
      buf_q   <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    count_d = count_q;
    ovr_d   = ovr_q;
    slot    = 32'(count_q[SW-1:0]);
    unique case (state_q)
      S_FILL: begin
        if (i_Flush) begin
          buf_d   = '0;
          count_d = '0;
        end else if (i_Rx_DV) begin
          buf_d = write_slot(buf_q, slot, i_Rx_Byte);
          if (count_q == CW'(BYTES_PER_BLOCK - 1)) begin
            state_d = S_HOLD;
            count_d = CW'(BYTES_PER_BLOCK);
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      S_HOLD: begin
        if (i_Block_Ready) begin
          state_d = S_FILL;
          buf_d   = '0;
          count_d = '0;
          // A byte arriving on the handshake cycle starts the next block.
          if (i_Rx_DV) begin
            buf_d   = write_slot('0, 0, i_Rx_Byte);
            count_d = CW'(1);
          end
        end else if (i_Rx_DV) begin
          ovr_d = 1'b1;
        end
      end
      default: begin
        state_d = S_FILL;
        buf_d   = '0;
        count_d = '0;
      end
    endcase
  end

  assign o_Block_Valid = (state_q == S_HOLD);
  assign o_Block       = o_Block_Valid ? buf_q : '0;
  assign o_Byte_Count  = count_q;
  assign o_Overrun     = ovr_q;

endmodule

// File: tb/tb_uart_block_packer.sv
// Scoreboard bench for uart_block_packer: completed blocks are queued as bytes
// are issued, and a negedge monitor checks every presented block.
module tb_uart_block_packer;

  logic         i_Clock = 1'b0;
  logic         i_Rst_n = 1'b0;
  logic         i_Rx_DV = 1'b0;
  logic [7:0]   i_Rx_Byte = '0;
  logic         i_Flush = 1'b0;
  logic [511:0] o_Block;
  logic         o_Block_Valid;
  logic         i_Block_Ready = 1'b0;
  logic [6:0]   o_Byte_Count;
  logic         o_Overrun;

  uart_block_packer #(.UART_DATA_WIDTH(8), .BYTES_PER_BLOCK(64)) dut (
    .i_Clock       (i_Clock),
    .i_Rst_n       (i_Rst_n),
    .i_Rx_DV       (i_Rx_DV),
    .i_Rx_Byte     (i_Rx_Byte),
    .i_Flush       (i_Flush),
    .o_Block       (o_Block),
    .o_Block_Valid (o_Block_Valid),
    .i_Block_Ready (i_Block_Ready),
    .o_Byte_Count  (o_Byte_Count),
    .o_Overrun     (o_Overrun)
  );

  always #5 i_Clock = ~i_Clock;

  int checks = 0;
  int errors = 0;

  logic [511:0] exp_q[$];
  logic [511:0] model_buf = '0;
  int           model_cnt = 0;
  bit           model_hold = 0;
  bit           exp_ovr = 0;
  bit           mon_en = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge i_Clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    if (!model_hold) begin
      model_buf[511-8*model_cnt -: 8] = b;
      model_cnt++;
      if (model_cnt == 64) begin
        exp_q.push_back(model_buf);
        model_hold = 1;
      end
    end else if (i_Block_Ready) begin
      model_hold = 0;
      model_buf  = '0;
      model_buf[511:504] = b;
      model_cnt  = 1;
    end else begin
      exp_ovr = 1;
    end
    tick();
    i_Rx_DV = 1'b0;
  endtask

  task automatic send_run(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) send_byte(first + 8'(i));
  endtask

  task automatic handshake;
    i_Block_Ready = 1'b1;
    if (model_hold) begin
      model_hold = 0;
      model_cnt  = 0;
      model_buf  = '0;
    end
    tick();
    i_Block_Ready = 1'b0;
  endtask

  task automatic do_reset;
    i_Rst_n = 1'b0;
    tick();
    i_Rst_n    = 1'b1;
    model_buf  = '0;
    model_cnt  = 0;
    model_hold = 0;
    exp_ovr    = 0;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".valid"},   512'(o_Block_Valid), 512'(model_hold));
    check({tag, ".count"},   512'(o_Byte_Count),  512'(model_cnt));
    check({tag, ".overrun"}, 512'(o_Overrun),     512'(exp_ovr));
  endtask

  // Monitor: new block popped on valid rise, held stable while valid, zero otherwise.
  logic [511:0] cur_exp;
  bit           prev_valid = 0;
  always @(negedge i_Clock) begin
    if (mon_en) begin
      if (o_Block_Valid) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon.unexpected_block: got %0h expected none", o_Block);
            cur_exp = o_Block;
          end else begin
            cur_exp = exp_q.pop_front();
          end
        end
        check("mon.block", o_Block, cur_exp);
        check("mon.hold_count", 512'(o_Byte_Count), 512'd64);
      end else begin
        check("mon.gated_block", o_Block, '0);
      end
      prev_valid = o_Block_Valid;
    end
  end

  initial begin
    do_reset();
    do_reset();
    mon_en = 1;
    check("rst.block", o_Block, '0);
    check_status("rst");

    // Block of 0x00..0x3F, back-to-back pulses.
    send_run(63, 8'h00);
    check_status("fill63");
    send_byte(8'h3F);
    check_status("full");
    check("full.first_byte", 512'(o_Block[511:504]), 512'h00);
    check("full.last_byte",  512'(o_Block[7:0]),     512'h3F);
    tick(); tick();
    i_Flush = 1'b1;
    tick();
    i_Flush = 1'b0;
    check_status("hold_flush_ignored");
    handshake();
    check("hs.block", o_Block, '0);
    check_status("hs");

    // Byte concurrent with handshake becomes slot 0 of the next block.
    send_run(64, 8'h40);
    tick();
    i_Block_Ready = 1'b1;
    send_byte(8'hA5);
    i_Block_Ready = 1'b0;
    check_status("hs_with_byte");
    send_run(63, 8'h01);
    check("a5.first_byte", 512'(o_Block[511:504]), 512'hA5);
    check_status("a5.full");
    handshake();

    // Overrun: byte dropped while block waits; sticky until reset.
    send_run(64, 8'hC0);
    send_byte(8'h77);
    check_status("overrun");
    tick();
    handshake();
    check_status("overrun_after_hs");
    send_run(5, 8'h20);
    check_status("overrun_sticky");
    do_reset();
    check_status("overrun_cleared");

    // Flush beats a same-cycle byte.
    send_run(10, 8'h60);
    i_Flush   = 1'b1;
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = 8'h11;
    model_buf = '0;
    model_cnt = 0;
    tick();
    i_Flush = 1'b0;
    i_Rx_DV = 1'b0;
    check_status("flush");
    send_run(64, 8'h80);
    handshake();

    // Reset mid-fill.
    send_run(30, 8'hE0);
    check_status("fill30");
    do_reset();
    check("rst2.block", o_Block, '0);
    check_status("rst2");
    send_run(64, 8'h3A);
    handshake();

    tick(); tick();
    check("scoreboard.drained", 512'(exp_q.size()), 512'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
